// File: rtl/bcd_scan_display_if.sv
// rtl/bcd_scan_display_if.sv - load/display signal bundle for the BCD scan display
// master drives the value/load side; slave is the display block.
interface bcd_scan_display_if #(
  parameter int NUM_DIGITS = 4,
  parameter int VAL_W      = 14
);
  logic [VAL_W-1:0]      value;
  logic                  load;
  logic                  blank_lz;
  logic                  busy;
  logic                  ovf;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] an;

  modport master (
    output value, load, blank_lz,
    input  busy, ovf, seg, an
  );

  modport slave (
    input  value, load, blank_lz,
    output busy, ovf, seg, an
  );
endinterface

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - binary to BCD (double dabble) with multiplexed 7-segment scan
// Digits only update when a conversion completes, so the scan never shows a partial result.
module bcd_scan_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int VAL_W       = 14,
  parameter int REFRESH_DIV = 50000
) (
  input  logic            clk,
  input  logic            rst_n,
  bcd_scan_display_if.slave bus
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(VAL_W) + 1;

  function automatic logic [63:0] max_value();
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < NUM_DIGITS; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_value();

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0:    seg_of = 7'b1000000;
      4'h1:    seg_of = 7'b1111001;
      4'h2:    seg_of = 7'b0100100;
      4'h3:    seg_of = 7'b0110000;
      4'h4:    seg_of = 7'b0011001;
      4'h5:    seg_of = 7'b0010010;
      4'h6:    seg_of = 7'b0000010;
      4'h7:    seg_of = 7'b1111000;
      4'h8:    seg_of = 7'b0000000;
      4'h9:    seg_of = 7'b0010000;
      4'hE:    seg_of = 7'b0000110;
      4'hF:    seg_of = 7'b0001110;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t                     state_q, state_d;
  logic [VAL_W-1:0]           bin_q, bin_d;
  logic [BW-1:0]              bcd_q, bcd_d, bcd_adj, bcd_step;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0][3:0] digit_q, digit_d;
  logic                       ovf_q, ovf_d;
  logic [RW-1:0]              ref_q, ref_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic                       over;
  logic                       upper_zero;
  logic                       blank;
  logic [3:0]                 cur;

  assign over = 64'(bus.value) > MAX_VAL;

  // One double-dabble step: add 3 to any digit >= 5, then shift in the next binary bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
    bcd_step = {bcd_adj[BW-2:0], bin_q[VAL_W-1]};
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          if (over) begin
            digit_d = {NUM_DIGITS{4'hE}};
            ovf_d   = 1'b1;
          end else begin
            state_d = CONVERT;
            bin_d   = bus.value;
            bcd_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      CONVERT: begin
        bin_d = bin_q << 1;
        bcd_d = bcd_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(VAL_W - 1)) begin
          state_d = IDLE;
          digit_d = bcd_step;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ref_d = ref_q + 1'b1;
    idx_d = idx_q;
    if (ref_q == RW'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      digit_q <= '0;
      ovf_q   <= 1'b0;
      ref_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      ovf_q   <= ovf_d;
      ref_q   <= ref_d;
      idx_q   <= idx_d;
    end
  end

  // Blank only when this digit and every more significant digit are zero; digit 0 always shows.
  always_comb begin
    cur        = digit_q[idx_q];
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx_q) && digit_q[i] != 4'd0) upper_zero = 1'b0;
    end
    blank   = bus.blank_lz && !ovf_q && (idx_q != '0) && upper_zero;
    bus.seg = blank ? 7'b1111111 : seg_of(cur);
    bus.an  = '1;
    bus.an[idx_q] = 1'b0;
  end

  assign bus.busy = (state_q == CONVERT);
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - directed bench for bcd_scan_display (4 digits, 14-bit value, refresh 4)
module tb_bcd_scan_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SB = 7'b1111111;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  bcd_scan_display_if #(.NUM_DIGITS(4), .VAL_W(14)) bus ();

  bcd_scan_display #(.NUM_DIGITS(4), .VAL_W(14), .REFRESH_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic load_value(input logic [13:0] v);
    @(negedge clk);
    bus.value = v;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (bus.busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic show_digit(input string tag, input int d, input logic [6:0] exp);
    logic [3:0] want;
    int         k;
    want = 4'b1111;
    want[d] = 1'b0;
    k = 0;
    while (bus.an !== want && k < 20) begin
      k++;
      @(negedge clk);
    end
    if (bus.an !== want) check({tag, "_timeout"}, {28'd0, bus.an}, {28'd0, want});
    else check(tag, {25'd0, bus.seg}, {25'd0, exp});
  endtask

  initial begin
    int   cnt;
    logic held;
    logic [3:0] an_exp;
    n_checks     = 0;
    n_pass       = 0;
    rst_n        = 1'b0;
    bus.value    = '0;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_ovf",  {31'd0, bus.ovf},  32'd0);
    check("rst_an",   {28'd0, bus.an},   32'hE);
    check("rst_seg",  {25'd0, bus.seg},  {25'd0, S0});

    // Scan after release: each anode held 4 cycles, wrapping back to digit 0.
    rst_n = 1'b1;
    held  = 1'b1;
    for (int k = 0; k < 17; k++) begin
      an_exp = 4'b1111;
      an_exp[(k / 4) % 4] = 1'b0;
      if (bus.an !== an_exp || bus.seg !== S0) held = 1'b0;
      if (k == 4 || k == 16) check($sformatf("scan_an_%0d", k), {28'd0, bus.an}, {28'd0, an_exp});
      @(negedge clk);
    end
    check("scan_seq", {31'd0, held}, 32'd1);

    // 1234: 14 busy cycles, old zeros held throughout, then 4,3,2,1.
    load_value(14'd1234);
    cnt  = 0;
    held = 1'b1;
    while (bus.busy && cnt < 40) begin
      cnt++;
      if (bus.seg !== S0) held = 1'b0;
      @(negedge clk);
    end
    check("c1234_busy", cnt, 32'd14);
    check("c1234_hold", {31'd0, held}, 32'd1);
    check("c1234_ovf",  {31'd0, bus.ovf}, 32'd0);
    show_digit("c1234_d0", 0, S4);
    show_digit("c1234_d1", 1, S3);
    show_digit("c1234_d2", 2, S2);
    show_digit("c1234_d3", 3, S1);

    // 7 with and without leading-zero blanking.
    load_value(14'd7);
    wait_idle(cnt);
    check("c7_busy", cnt, 32'd14);
    bus.blank_lz = 1'b1;
    show_digit("c7_lz_d0", 0, S7);
    show_digit("c7_lz_d1", 1, SB);
    show_digit("c7_lz_d2", 2, SB);
    show_digit("c7_lz_d3", 3, SB);
    bus.blank_lz = 1'b0;
    show_digit("c7_d1", 1, S0);
    show_digit("c7_d3", 3, S0);

    // Overflow: immediate E pattern, no conversion.
    load_value(14'd12000);
    check("ovf_flag", {31'd0, bus.ovf},  32'd1);
    check("ovf_busy", {31'd0, bus.busy}, 32'd0);
    for (int d = 0; d < 4; d++) show_digit($sformatf("ovf_d%0d", d), d, SE);

    load_value(14'd5);
    check("c5_ovf_during", {31'd0, bus.ovf}, 32'd1);
    wait_idle(cnt);
    check("c5_busy", cnt, 32'd14);
    check("c5_ovf",  {31'd0, bus.ovf}, 32'd0);
    show_digit("c5_d0", 0, S5);

    // Load of 99 at busy cycle 5 must be dropped.
    load_value(14'd42);
    cnt = 0;
    while (bus.busy && cnt < 40) begin
      cnt++;
      if (cnt == 5) begin
        bus.value = 14'd99;
        bus.load  = 1'b1;
      end else begin
        bus.load  = 1'b0;
      end
      @(negedge clk);
    end
    bus.load = 1'b0;
    check("c42_busy", cnt, 32'd14);
    repeat (3) @(negedge clk);
    check("c42_nosecond", {31'd0, bus.busy}, 32'd0);
    show_digit("c42_d0", 0, S2);
    show_digit("c42_d1", 1, S4);
    show_digit("c42_d2", 2, S0);

    // Reset dropped mid-conversion, away from any clock edge.
    load_value(14'd9999);
    repeat (6) @(negedge clk);
    check("c9999_busy7", {31'd0, bus.busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_seg",  {25'd0, bus.seg},  {25'd0, S0});
    check("arst_an",   {28'd0, bus.an},   32'hE);
    @(negedge clk);
    rst_n = 1'b1;
    show_digit("arst_d1", 1, S0);
    show_digit("arst_d3", 3, S0);

    load_value(14'd3);
    wait_idle(cnt);
    check("c3_busy", cnt, 32'd14);
    show_digit("c3_d0", 0, S3);
    show_digit("c3_d1", 1, S0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter VAL_W, default 14: width of the binary input value.
REQ-003 Parameter REFRESH_DIV, default 50000: clock cycles per digit slot, minimum 2.
REQ-004 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port value, input, VAL_W: unsigned binary number to display, sampled only when load is accepted.
REQ-007 Port load, input, 1: load request, sampled each cycle.
REQ-008 Port blank_lz, input, 1: when high, leading zeros are blanked; sampled live, not latched.
REQ-009 Port busy, output, 1: high while a conversion is in progress.
REQ-010 Port ovf, output, 1: high while the displayed content is the overflow pattern.
REQ-011 Port seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
REQ-012 Port an, output, NUM_DIGITS: digit enables, active-low one-hot.

Function
REQ-013 Load shall be accepted only in state IDLE; load while busy=1 shall be ignored, with no queuing.
REQ-014 Accepted load with value <= 10^NUM_DIGITS-1 shall go to CONVERT, set busy=1 from the next cycle, and run a shift-add-3 (double-dabble) conversion of exactly VAL_W cycles.
REQ-015 At the end of CONVERT, all NUM_DIGITS BCD digit registers shall update in the same cycle, ovf shall be cleared, and the block shall return to IDLE with busy=0, VAL_W+1 cycles after the load edge.
REQ-016 Digit registers shall hold the previous value throughout CONVERT; no partial result shall ever be displayed.
REQ-017 Accepted load with value > 10^NUM_DIGITS-1 shall not enter CONVERT; on the next cycle every digit register shall be set to 4'hE, ovf=1, and busy shall stay 0.
REQ-018 State machine: IDLE->CONVERT on valid load; IDLE->IDLE on overflow load (digits forced to E); CONVERT->IDLE after VAL_W shift cycles; no other transitions.
REQ-019 Refresh counter shall count 0..REFRESH_DIV-1 and wrap to 0.
REQ-020 On the wrap cycle, digit index shall advance 0,1,..,NUM_DIGITS-1 and then wrap to 0; digit 0 is the least significant digit.
REQ-021 an shall drive bit [index] low and all other bits high; seg shall show the decoded digit register [index]; both shall be combinational from registered state.
REQ-022 Hex encoding (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, E=0000110, F=0001110.
REQ-023 Leading-zero blank applies when blank_lz=1, ovf=0, and every digit at or above the current index is 0:
- seg shall be 1111111 (all segments off).
- Digit 0 shall never be blanked.
- an shall keep sequencing normally.
REQ-024 The scan shall run continuously and independently of load, busy, and ovf.

Reset
REQ-025 While rst_n=0:
- state IDLE, busy=0, ovf=0;
- refresh counter 0, digit index 0;
- all digit registers 0;
- an = all ones except bit0 low, seg = 1000000.
REQ-026 Reset asserted mid-CONVERT shall abort the conversion immediately; after release the display shows 0 and the next load is accepted.

Verification (NUM_DIGITS=4, VAL_W=14, REFRESH_DIV=4)
REQ-027 Release reset, no load: an cycles 1110->1101->1011->0111->1110, each held 4 cycles; seg=1000000 throughout (blank_lz=0).
REQ-028 load=1, value=1234 for one cycle: busy high for 14 cycles; at cycle 15 the digits become 4,3,2,1; scanned seg sequence 0011001, 0110000, 0100100, 1111001.
REQ-029 value=7, blank_lz=1: digit0 shows 1111000; digits 1-3 show 1111111. With blank_lz=0, digits 1-3 show 1000000.
REQ-030 value=12000 load: next cycle ovf=1, busy=0, all four digits show 0000110. A following load of 5 clears ovf after conversion.
REQ-031 Load 42, then pulse load=1 with value=99 at busy cycle 5: the display ends at 42, and no second conversion starts.
REQ-032 Drop rst_n at busy cycle 7 of a load of 9999: busy=0 and seg=1000000 immediately, asynchronous to clk.
